// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment clock scanner.
// Segment patterns are active-low, bit 0..6 = a..g (dp is handled by the top).
package seg7_pkg;

   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } scan_state_t;

   typedef logic [1:0] dig_idx_t;

   typedef struct packed {
      logic [7:0] hours;
      logic [7:0] minutes;
      logic       colon;
      logic [3:0] blink_mask;
   } snap_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [7:0] SEG8_OFF  = 8'hFF;
   localparam logic [3:0] DIG_OFF   = 4'hF;

   // Active-low one-cold digit enable for a digit index.
   function automatic logic [3:0] dig_select(input dig_idx_t idx);
      logic [3:0] sel;
      case (idx)
         2'd0:    sel = 4'hE;
         2'd1:    sel = 4'hD;
         2'd2:    sel = 4'hB;
         2'd3:    sel = 4'h7;
         default: sel = 4'hF;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder; non-BCD nibbles show a dash.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Map each nibble to its active-low a..g pattern.
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_clock_scan.sv
// Multiplexed 4-digit clock display scanner (HH:MM) with per-frame input
// snapshot, dead time between digits and per-digit blinking.
// Optional build macro SEG7_LZ_BLANK_EN: blank the hours-tens digit when it
// is zero instead of showing "0".
// All outputs are registered; the output registers are loaded from the
// next-state values so they change on the same edge as state/idx.
module seg7_clock_scan
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned DEAD_CYCLES  = 4,
   parameter int unsigned BLINK_FRAMES = 250
)
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_hours,
   input  logic [7:0] i_minutes,
   input  logic       i_colon,
   input  logic [3:0] i_blink_mask,
   output logic [7:0] o_seg,
   output logic [3:0] o_dig,
   output logic       o_frame
);

   // One prescaler serves both states, so it is as wide as the larger need.
   localparam int RW_RAW = $clog2(REFRESH_DIV);
   localparam int DW_RAW = $clog2(DEAD_CYCLES);
   localparam int FW_RAW = $clog2(BLINK_FRAMES);
   localparam int PW_MAX = (RW_RAW > DW_RAW) ? RW_RAW : DW_RAW;
   localparam int PW     = (PW_MAX > 0) ? PW_MAX : 1;
   localparam int FW     = (FW_RAW > 0) ? FW_RAW : 1;

   localparam logic [PW-1:0] DRIVE_LAST = PW'((REFRESH_DIV > 0) ? REFRESH_DIV - 1 : 0);
   localparam logic [PW-1:0] DEAD_LAST  = PW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
   localparam logic [PW-1:0] CNT_ONE    = PW'(1);
   localparam logic [PW-1:0] CNT_ZERO   = PW'(0);
   localparam logic [FW-1:0] FRAME_LAST = FW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
   localparam logic [FW-1:0] FRM_ONE    = FW'(1);
   localparam logic [FW-1:0] FRM_ZERO   = FW'(0);
   localparam bit            SKIP_BLANK = (DEAD_CYCLES == 0);

`ifdef SEG7_LZ_BLANK_EN
   localparam bit LZ_BLANK = 1'b1;
`else
   localparam bit LZ_BLANK = 1'b0;
`endif

   scan_state_t   state;
   scan_state_t   state_n;
   dig_idx_t      idx;
   dig_idx_t      idx_n;
   logic [PW-1:0] cnt;
   logic [PW-1:0] cnt_n;
   logic          restart;
   logic          frame_start;
   logic [FW-1:0] fcnt;
   logic [FW-1:0] fcnt_n;
   logic          phase;
   logic          phase_n;
   snap_t         snap;
   snap_t         snap_n;
   logic [3:0]    nibble;
   logic [6:0]    dec_seg;
   logic [7:0]    seg_n;
   logic [3:0]    dig_n;

   // State, digit index, prescaler and restart flag registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= S_BLANK;
         idx     <= 2'd0;
         cnt     <= CNT_ZERO;
         restart <= 1'b1;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         cnt     <= cnt_n;
         restart <= 1'b0;
      end
   end

   // Next-state logic: dead time then drive per digit, restart after reset.
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      cnt_n       = cnt + CNT_ONE;
      frame_start = 1'b0;
      if (restart) begin
         state_n     = SKIP_BLANK ? S_DRIVE : S_BLANK;
         idx_n       = 2'd0;
         cnt_n       = CNT_ZERO;
         frame_start = 1'b1;
      end else begin
         case (state)
            S_BLANK: begin
               if (cnt == DEAD_LAST) begin
                  state_n = S_DRIVE;
                  cnt_n   = CNT_ZERO;
               end else begin
                  state_n = S_BLANK;
               end
            end
            S_DRIVE: begin
               if (cnt == DRIVE_LAST) begin
                  state_n     = SKIP_BLANK ? S_DRIVE : S_BLANK;
                  idx_n       = idx + 2'd1;
                  cnt_n       = CNT_ZERO;
                  frame_start = (idx == 2'd3);
               end else begin
                  state_n = S_DRIVE;
               end
            end
            default: begin
               state_n = S_BLANK;
               idx_n   = 2'd0;
               cnt_n   = CNT_ZERO;
            end
         endcase
      end
   end

   // Next snapshot: inputs are captured only at the start of a frame.
   always_comb begin
      if (frame_start) begin
         snap_n = '{hours: i_hours, minutes: i_minutes,
                    colon: i_colon, blink_mask: i_blink_mask};
      end else begin
         snap_n = snap;
      end
   end

   // Next frame counter and blink phase; the post-reset frame is frame 0.
   always_comb begin
      fcnt_n  = fcnt;
      phase_n = phase;
      if (frame_start && !restart) begin
         if (fcnt == FRAME_LAST) begin
            fcnt_n  = FRM_ZERO;
            phase_n = ~phase;
         end else begin
            fcnt_n  = fcnt + FRM_ONE;
         end
      end else begin
         fcnt_n  = fcnt;
         phase_n = phase;
      end
   end

   // Snapshot, frame counter and blink phase registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         snap  <= '0;
         fcnt  <= FRM_ZERO;
         phase <= 1'b0;
      end else begin
         snap  <= snap_n;
         fcnt  <= fcnt_n;
         phase <= phase_n;
      end
   end

   // Select the BCD nibble for the digit about to be driven.
   always_comb begin
      nibble = 4'h0;
      case (idx_n)
         2'd0:    nibble = snap_n.minutes[3:0];
         2'd1:    nibble = snap_n.minutes[7:4];
         2'd2:    nibble = snap_n.hours[3:0];
         2'd3:    nibble = snap_n.hours[7:4];
         default: nibble = 4'h0;
      endcase
   end

   seg7_decode u_decode (
      .bcd (nibble),
      .seg (dec_seg)
   );

   // Output pattern for the next cycle: blanking, blink, leading zero, dp.
   always_comb begin
      seg_n = SEG8_OFF;
      dig_n = DIG_OFF;
      if (state_n == S_DRIVE) begin
         dig_n = dig_select(idx_n);
         if (phase_n && snap_n.blink_mask[idx_n]) begin
            seg_n = SEG8_OFF;
         end else if (LZ_BLANK && (idx_n == 2'd3) && (snap_n.hours[7:4] == 4'h0)) begin
            seg_n = SEG8_OFF;
         end else begin
            seg_n = {~(snap_n.colon && (idx_n == 2'd2)), dec_seg};
         end
      end else begin
         seg_n = SEG8_OFF;
         dig_n = DIG_OFF;
      end
   end

   // Registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_seg   <= SEG8_OFF;
         o_dig   <= DIG_OFF;
         o_frame <= 1'b0;
      end else begin
         o_seg   <= seg_n;
         o_dig   <= dig_n;
         o_frame <= frame_start;
      end
   end

endmodule

// File: tb/tb_seg7_clock_scan.sv
// Directed self-checking bench for seg7_clock_scan with
// REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2 (20-clock frames).
module tb_seg7_clock_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] hours = 8'h12;
   logic [7:0] minutes = 8'h45;
   logic       colon = 1'b0;
   logic [3:0] blink_mask = 4'h0;
   logic [7:0] seg;
   logic [3:0] dig;
   logic       frame;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SEG7_LZ_BLANK_EN
   localparam logic [7:0] LZ_SEG = 8'hFF;
`else
   localparam logic [7:0] LZ_SEG = 8'hC0;
`endif

   seg7_clock_scan #(
      .REFRESH_DIV  (4),
      .DEAD_CYCLES  (1),
      .BLINK_FRAMES (2)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_hours      (hours),
      .i_minutes    (minutes),
      .i_colon      (colon),
      .i_blink_mask (blink_mask),
      .o_seg        (seg),
      .o_dig        (dig),
      .o_frame      (frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic blank_clk(input string tag, input logic frame_exp);
      step();
      check({tag, "_blank_seg"}, seg, 8'hFF);
      check({tag, "_blank_dig"}, {4'h0, dig}, 8'h0F);
      check({tag, "_blank_frame"}, {7'h0, frame}, {7'h0, frame_exp});
   endtask

   task automatic drive_clks(input string tag, input int d, input logic [7:0] seg_exp, input int n);
      logic [3:0] dig_exp;
      case (d)
         0:       dig_exp = 4'hE;
         1:       dig_exp = 4'hD;
         2:       dig_exp = 4'hB;
         default: dig_exp = 4'h7;
      endcase
      for (int k = 0; k < n; k++) begin
         step();
         check($sformatf("%s_d%0d_seg", tag, d), seg, seg_exp);
         check($sformatf("%s_d%0d_dig", tag, d), {4'h0, dig}, {4'h0, dig_exp});
         check($sformatf("%s_d%0d_frame", tag, d), {7'h0, frame}, 8'h00);
      end
   endtask

   task automatic run_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
      blank_clk(tag, 1'b1);
      drive_clks(tag, 0, s0, 4);
      blank_clk(tag, 1'b0);
      drive_clks(tag, 1, s1, 4);
      blank_clk(tag, 1'b0);
      drive_clks(tag, 2, s2, 4);
      blank_clk(tag, 1'b0);
      drive_clks(tag, 3, s3, 4);
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_seg", seg, 8'hFF);
      check("rst_dig", {4'h0, dig}, 8'h0F);
      check("rst_frame", {7'h0, frame}, 8'h00);

      // 12:45, colon off
      rst = 1'b0;
      run_frame("f_1245", 8'h92, 8'h99, 8'hA4, 8'hF9);

      // Hours change while digit 2 is driven is held off until next frame
      blank_clk("chg", 1'b1);
      drive_clks("chg", 0, 8'h92, 4);
      blank_clk("chg", 1'b0);
      drive_clks("chg", 1, 8'h99, 4);
      blank_clk("chg", 1'b0);
      drive_clks("chg", 2, 8'hA4, 2);
      hours = 8'h11;
      drive_clks("chg", 2, 8'hA4, 2);
      blank_clk("chg", 1'b0);
      drive_clks("chg", 3, 8'hF9, 4);
      run_frame("f_1145", 8'h92, 8'h99, 8'hF9, 8'hF9);

      // Leading zero and non-BCD nibble
      hours   = 8'h09;
      minutes = 8'h3A;
      run_frame("f_093A", 8'hBF, 8'hB0, 8'h90, LZ_SEG);

      // Blink and colon, aligned to a fresh reset
      rst = 1'b1;
      step();
      check("rst2_seg", seg, 8'hFF);
      check("rst2_dig", {4'h0, dig}, 8'h0F);
      hours      = 8'h12;
      minutes    = 8'h45;
      colon      = 1'b1;
      blink_mask = 4'hC;
      rst        = 1'b0;
      run_frame("blink_f0", 8'h92, 8'h99, 8'h24, 8'hF9);
      run_frame("blink_f1", 8'h92, 8'h99, 8'h24, 8'hF9);
      run_frame("blink_f2", 8'h92, 8'h99, 8'hFF, 8'hFF);
      run_frame("blink_f3", 8'h92, 8'h99, 8'hFF, 8'hFF);
      run_frame("blink_f4", 8'h92, 8'h99, 8'h24, 8'hF9);

      // Reset asserted while digit 1 is driven
      colon      = 1'b0;
      blink_mask = 4'h0;
      blank_clk("mid", 1'b1);
      drive_clks("mid", 0, 8'h92, 4);
      blank_clk("mid", 1'b0);
      drive_clks("mid", 1, 8'h99, 2);
      rst = 1'b1;
      step();
      check("mid_rst_seg", seg, 8'hFF);
      check("mid_rst_dig", {4'h0, dig}, 8'h0F);
      check("mid_rst_frame", {7'h0, frame}, 8'h00);
      step();
      rst = 1'b0;
      run_frame("after_rst", 8'h92, 8'h99, 8'hA4, 8'hF9);
      blank_clk("next", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
